// File: rtl/otter_dcache_pkg.sv
// Shared types and address-field helpers for the OTTER direct-mapped data cache.
package otter_dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } dcache_state_t;

  localparam int ADDR_W    = 32;
  localparam int BYTE_BITS = 2;

  // Bits below the index: byte offset plus word-in-line select.
  function automatic int off_bits(input int words);
    return $clog2(words) + BYTE_BITS;
  endfunction

  function automatic int tag_bits(input int lines, input int words);
    return ADDR_W - off_bits(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/data/valid/dirty storage for the data cache; one shared line index for all ports.
module dcache_line_store #(
  parameter  int LINES = 16,
  parameter  int WORDS = 4,
  parameter  int TAG_W = 24,
  localparam int IDX_W = $clog2(LINES),
  localparam int WRD_W = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      idx,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [WORDS*32-1:0]   rd_line,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  input  logic                  wr_en,
  input  logic [WRD_W-1:0]      wr_word,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data,
  input  logic                  fill_en,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [WORDS*32-1:0]   fill_line,
  input  logic                  clean_en
);

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [WORDS*32-1:0] data_mem [LINES];
  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;

  assign rd_tag   = tag_mem[idx];
  assign rd_line  = data_mem[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

  // Payload arrays carry no reset; valid bits gate any use of stale contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[idx]  <= fill_tag;
      data_mem[idx] <= fill_line;
    end else if (wr_en) begin
      for (int w = 0; w < WORDS; w++) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_word == WRD_W'(w) && wr_be[b]) begin
            data_mem[idx][w*32 + b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else begin
      if (wr_en)    dirty_q[idx] <= 1'b1;
      if (clean_en) dirty_q[idx] <= 1'b0;
    end
  end

endmodule

// File: rtl/otter_dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller for the OTTER MEM stage.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
module otter_dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                DC_CLK,
  input  logic                DC_RESET_N,
  input  logic                DC_MEMREAD,
  input  logic                DC_MEMWRITE,
  input  logic [31:0]         DC_ADDR,
  input  logic [3:0]          DC_BE,
  input  logic [31:0]         DC_WDATA,
  output logic [31:0]         DC_RDATA,
  output logic                DC_STALL,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [31:0]         MEM_ADDR,
  output logic [WORDS*32-1:0] MEM_WDATA,
  input  logic                MEM_ACK,
  input  logic [WORDS*32-1:0] MEM_RDATA,
  output logic [1:0]          DC_DBG_STATE
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]         DC_HITS,
  output logic [31:0]         DC_MISSES
`endif
);
  import otter_dcache_pkg::*;

  localparam int OFF_W = off_bits(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int WRD_W = $clog2(WORDS);
  localparam int TAG_W = tag_bits(LINES, WORDS);

  // Handshakes: a pipeline request (MEMREAD|MEMWRITE) completes on the rising edge
  // where DC_STALL=0; a memory transfer holds MEM_REQ and its payload steady until
  // the edge where MEM_ACK=1, and MEM_ACK without MEM_REQ is ignored.

  dcache_state_t       state_q, state_d;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [WRD_W-1:0]    req_word;
  logic [TAG_W-1:0]    rd_tag;
  logic [WORDS*32-1:0] rd_line;
  logic                rd_valid, rd_dirty;
  logic                access, hit, ack_ok, miss_start;
  logic                store_hit, fill_en, clean_en, stall;
  logic [31:0]         sel_word, rdata;
  logic                mem_req_q, mem_we_q;
  logic [31:0]         mem_addr_q;
  logic [WORDS*32-1:0] mem_wdata_q;
  logic                addr_unused;

  assign req_idx     = DC_ADDR[OFF_W +: IDX_W];
  assign req_tag     = DC_ADDR[31 -: TAG_W];
  assign req_word    = DC_ADDR[2 +: WRD_W];
  assign addr_unused = ^DC_ADDR[1:0];

  assign access     = DC_MEMREAD | DC_MEMWRITE;
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign ack_ok     = MEM_ACK && mem_req_q;
  assign miss_start = (state_q == IDLE) && access && !hit;

  dcache_line_store #(.LINES(LINES), .WORDS(WORDS), .TAG_W(TAG_W)) u_store (
    .clk      (DC_CLK),
    .rst_n    (DC_RESET_N),
    .idx      (req_idx),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .wr_en    (store_hit),
    .wr_word  (req_word),
    .wr_be    (DC_BE),
    .wr_data  (DC_WDATA),
    .fill_en  (fill_en),
    .fill_tag (req_tag),
    .fill_line(MEM_RDATA),
    .clean_en (clean_en)
  );

  always_comb begin
    sel_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (req_word == WRD_W'(w)) sel_word = rd_line[w*32 +: 32];
    end
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    store_hit = 1'b0;
    fill_en   = 1'b0;
    clean_en  = 1'b0;
    rdata     = '0;
    case (state_q)
      IDLE: begin
        if (access && hit) begin
          store_hit = DC_MEMWRITE;
          if (!DC_MEMWRITE) rdata = sel_word;
        end else if (access) begin
          stall   = 1'b1;
          state_d = rd_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        stall = 1'b1;
        if (ack_ok) begin
          clean_en = 1'b1;
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall = 1'b1;
        if (ack_ok) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must quiet the pipeline outputs immediately, even with a request held.
  assign DC_STALL     = stall && DC_RESET_N;
  assign DC_RDATA     = DC_RESET_N ? rdata : 32'h0;
  assign DC_DBG_STATE = state_q;

  always_ff @(posedge DC_CLK or negedge DC_RESET_N) begin
    if (!DC_RESET_N) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= rd_dirty;
        mem_addr_q  <= rd_dirty ? {rd_tag, req_idx, {OFF_W{1'b0}}}
                                : {req_tag, req_idx, {OFF_W{1'b0}}};
        mem_wdata_q <= rd_line;
      end else if (state_q == WRITEBACK && ack_ok) begin
        mem_we_q   <= 1'b0;
        mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}};
      end else if (state_q == ALLOCATE && ack_ok) begin
        mem_req_q <= 1'b0;
      end
    end
  end

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic        miss_pend_q;
  logic [31:0] hits_q, misses_q;

  // The hit that finally completes a missed request is not a separate hit.
  always_ff @(posedge DC_CLK or negedge DC_RESET_N) begin
    if (!DC_RESET_N) begin
      miss_pend_q <= 1'b0;
      hits_q      <= '0;
      misses_q    <= '0;
    end else begin
      if (miss_start) begin
        miss_pend_q <= 1'b1;
        misses_q    <= misses_q + 32'd1;
      end else if (state_q == IDLE && access && hit) begin
        miss_pend_q <= 1'b0;
        if (!miss_pend_q) hits_q <= hits_q + 32'd1;
      end
    end
  end

  assign DC_HITS   = hits_q;
  assign DC_MISSES = misses_q;
`endif

endmodule

// File: tb/tb_otter_dcache_ctrl.sv
// Self-checking bench for otter_dcache_ctrl: directed cases plus random traffic against a flat-memory model.
module tb_otter_dcache_ctrl;
  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int OFFB  = $clog2(WORDS) + 2;
  localparam int IDXB  = $clog2(LINES);

  logic                DC_CLK, DC_RESET_N, DC_MEMREAD, DC_MEMWRITE;
  logic [31:0]         DC_ADDR, DC_WDATA, DC_RDATA, MEM_ADDR;
  logic [3:0]          DC_BE;
  logic                DC_STALL, MEM_REQ, MEM_WE, MEM_ACK;
  logic [WORDS*32-1:0] MEM_WDATA, MEM_RDATA;
  logic [1:0]          DC_DBG_STATE;
`ifdef DCACHE_STATS_EN
  logic [31:0]         DC_HITS, DC_MISSES;
`endif

  otter_dcache_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
    .DC_CLK(DC_CLK), .DC_RESET_N(DC_RESET_N), .DC_MEMREAD(DC_MEMREAD),
    .DC_MEMWRITE(DC_MEMWRITE), .DC_ADDR(DC_ADDR), .DC_BE(DC_BE),
    .DC_WDATA(DC_WDATA), .DC_RDATA(DC_RDATA), .DC_STALL(DC_STALL),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .DC_DBG_STATE(DC_DBG_STATE)
`ifdef DCACHE_STATS_EN
    , .DC_HITS(DC_HITS), .DC_MISSES(DC_MISSES)
`endif
  );

  // clock/reset
  initial begin
    DC_CLK = 1'b0;
    forever #5 DC_CLK = ~DC_CLK;
  end

  int checks = 0;
  int errors = 0;

  // scoreboard state
  logic [32:0] mem_exp_q[$];   // {we, line address} per expected memory transfer
  logic [31:0] exp_q[$];       // expected load data in completion order
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bk_mem  [int unsigned];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int unsigned m_tag   [LINES];
  int          exp_hits, exp_misses;
  bit          slave_hold = 0;

  function automatic logic [31:0] init_word(int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(int unsigned wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] bk_rd(int unsigned wa);
    return bk_mem.exists(wa) ? bk_mem[wa] : init_word(wa);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  // Cache contents are lost on reset; memory then holds the only valid copy.
  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    ref_mem = bk_mem;
    exp_hits = 0;
    exp_misses = 0;
    mem_exp_q.delete();
    exp_q.delete();
  endtask

  // memory responder: checks each new transfer, acks after a random delay
  initial begin
    bit          in_xfer;
    int          wait_n;
    logic [32:0] e;
    int unsigned la;
    MEM_ACK = 1'b0;
    MEM_RDATA = '0;
    in_xfer = 0;
    wait_n = 0;
    forever begin
      @(negedge DC_CLK);
      if (MEM_ACK) begin
        MEM_ACK = 1'b0;
        in_xfer = 0;
      end else if (MEM_REQ && DC_RESET_N) begin
        la = MEM_ADDR >> 2;
        if (!in_xfer) begin
          in_xfer = 1;
          wait_n = $urandom_range(0, 3);
          if (mem_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_txn_unexpected actual we=%b addr=%h expected none", MEM_WE, MEM_ADDR);
          end else begin
            e = mem_exp_q.pop_front();
            check("mem_we", 64'(MEM_WE), 64'(e[32]));
            check("mem_addr", 64'(MEM_ADDR), 64'(e[31:0]));
          end
          if (MEM_WE) begin
            for (int w = 0; w < WORDS; w++)
              check("wb_data", 64'(MEM_WDATA[w*32 +: 32]), 64'(ref_rd(la + w)));
          end
        end
        if (!slave_hold) begin
          if (wait_n == 0) begin
            MEM_ACK = 1'b1;
            for (int w = 0; w < WORDS; w++) begin
              if (MEM_WE) bk_mem[la + w] = MEM_WDATA[w*32 +: 32];
              else        MEM_RDATA[w*32 +: 32] = bk_rd(la + w);
            end
          end else begin
            wait_n--;
          end
        end
      end else begin
        in_xfer = 0;
      end
    end
  end

  // load monitor: compares every completing load against the queue head
  initial begin
    forever begin
      @(negedge DC_CLK);
      #2;
      if (DC_RESET_N && DC_MEMREAD && !DC_MEMWRITE && !DC_STALL) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL load_unexpected actual=%h expected none", DC_RDATA);
        end else begin
          check("load_data", 64'(DC_RDATA), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // driver: issue one request at a negedge, hold it until it completes
  task automatic do_access(bit rd, bit wr, logic [31:0] addr, logic [3:0] be, logic [31:0] wd);
    int unsigned wa, idx, tag;
    bit          miss;
    int          n;
    logic [31:0] word;
    wa   = addr >> 2;
    idx  = (addr >> OFFB) % LINES;
    tag  = addr >> (OFFB + IDXB);
    miss = !(m_valid[idx] && m_tag[idx] == tag);
    if (miss) begin
      exp_misses++;
      if (m_valid[idx] && m_dirty[idx])
        mem_exp_q.push_back({1'b1, 32'((m_tag[idx] << (OFFB + IDXB)) | (idx << OFFB))});
      mem_exp_q.push_back({1'b0, addr & ~32'((1 << OFFB) - 1)});
      m_valid[idx] = 1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 0;
    end else begin
      exp_hits++;
    end
    if (wr) begin
      m_dirty[idx] = 1;
      word = ref_rd(wa);
      for (int b = 0; b < 4; b++) if (be[b]) word[b*8 +: 8] = wd[b*8 +: 8];
      ref_mem[wa] = word;
    end else begin
      exp_q.push_back(ref_rd(wa));
    end
    DC_MEMREAD = rd;
    DC_MEMWRITE = wr;
    DC_ADDR = addr;
    DC_BE = be;
    DC_WDATA = wd;
    #1;
    check("stall_on_issue", 64'(DC_STALL), 64'(miss));
    n = 0;
    while (DC_STALL && n < 200) begin
      @(negedge DC_CLK);
      #1;
      n++;
    end
    if (DC_STALL) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout actual=stalled expected=complete addr=%h", addr);
      report();
      $finish;
    end
    if (miss) check("mem_q_drained", 64'(mem_exp_q.size()), 64'd0);
    @(posedge DC_CLK);
    @(negedge DC_CLK);
    DC_MEMREAD = 1'b0;
    DC_MEMWRITE = 1'b0;
  endtask

  initial begin
    DC_RESET_N = 1'b0;
    DC_MEMREAD = 1'b0;
    DC_MEMWRITE = 1'b0;
    DC_ADDR = '0;
    DC_BE = '0;
    DC_WDATA = '0;
    bk_mem[32'h104 >> 2] = 32'hDEAD_BEEF;
    model_reset();
    #1;
    check("rst_stall", 64'(DC_STALL), 64'd0);
    check("rst_mem_req", 64'(MEM_REQ), 64'd0);
    check("rst_mem_we", 64'(MEM_WE), 64'd0);
    check("rst_rdata", 64'(DC_RDATA), 64'd0);
    check("rst_state", 64'(DC_DBG_STATE), 64'(otter_dcache_pkg::IDLE));
    repeat (3) @(negedge DC_CLK);
    DC_RESET_N = 1'b1;
    @(negedge DC_CLK);

    // cold fill, hit, partial store, writeback, clean conflict
    do_access(1, 0, 32'h100, 4'h0, 32'h0);
    do_access(1, 0, 32'h104, 4'h0, 32'h0);
    do_access(0, 1, 32'h104, 4'b0011, 32'h0000_1234);
    do_access(1, 0, 32'h104, 4'h0, 32'h0);
    do_access(1, 0, 32'h200, 4'h0, 32'h0);
    do_access(1, 0, 32'h204, 4'h0, 32'h0);
    do_access(1, 0, 32'h300, 4'h0, 32'h0);
    do_access(0, 1, 32'h308, 4'h0, 32'hFFFF_FFFF);
    do_access(1, 1, 32'h30C, 4'hF, 32'hCAFE_F00D);
    do_access(1, 0, 32'h30C, 4'h0, 32'h0);
`ifdef DCACHE_STATS_EN
    check("stats_hits_dir", 64'(DC_HITS), 64'(exp_hits));
    check("stats_misses_dir", 64'(DC_MISSES), 64'(exp_misses));
`endif

    // reset while an allocate is outstanding
    do_access(1, 0, 32'hA00, 4'h0, 32'h0);
    slave_hold = 1;
    mem_exp_q.push_back({1'b0, 32'hB00});
    DC_MEMREAD = 1'b1;
    DC_ADDR = 32'hB00;
    repeat (3) @(negedge DC_CLK);
    #1;
    check("hold_mem_req", 64'(MEM_REQ), 64'd1);
    check("hold_mem_we", 64'(MEM_WE), 64'd0);
    check("hold_mem_addr", 64'(MEM_ADDR), 64'h0000_0B00);
    check("hold_state", 64'(DC_DBG_STATE), 64'(otter_dcache_pkg::ALLOCATE));
    DC_RESET_N = 1'b0;
    #1;
    check("midrst_mem_req", 64'(MEM_REQ), 64'd0);
    check("midrst_stall", 64'(DC_STALL), 64'd0);
    check("midrst_rdata", 64'(DC_RDATA), 64'd0);
    @(negedge DC_CLK);
    DC_MEMREAD = 1'b0;
    model_reset();
    slave_hold = 0;
    @(negedge DC_CLK);
    DC_RESET_N = 1'b1;
    @(negedge DC_CLK);
`ifdef DCACHE_STATS_EN
    check("stats_hits_rst", 64'(DC_HITS), 64'd0);
    check("stats_misses_rst", 64'(DC_MISSES), 64'd0);
    do_access(1, 0, 32'h100, 4'h0, 32'h0);
    do_access(1, 0, 32'h100, 4'h0, 32'h0);
    do_access(1, 0, 32'h104, 4'h0, 32'h0);
    do_access(0, 1, 32'h108, 4'hF, 32'h1357_9BDF);
    check("stats_hits_3", 64'(DC_HITS), 64'd3);
    check("stats_misses_1", 64'(DC_MISSES), 64'd1);
`endif
    do_access(1, 0, 32'hA00, 4'h0, 32'h0);

    // random traffic over a few tags and indices to force conflicts
    for (int i = 0; i < 400; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) << (OFFB + IDXB)) | ($urandom_range(0, 3) << OFFB) |
           ($urandom_range(0, WORDS - 1) << 2) | $urandom_range(0, 3);
      do_access(op <= 4 || op == 9, op >= 5, a, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge DC_CLK);
    end

    check("load_q_empty", 64'(exp_q.size()), 64'd0);
    check("mem_q_empty", 64'(mem_exp_q.size()), 64'd0);
`ifdef DCACHE_STATS_EN
    check("stats_hits_end", 64'(DC_HITS), 64'(exp_hits));
    check("stats_misses_end", 64'(DC_MISSES), 64'(exp_misses));
`endif
    report();
    $finish;
  end

endmodule
